// File: rtl/affine_cand_sched_if.sv
// Datapath bus between the candidate scheduler (master) and affine_top (slave).
interface affine_cand_sched_if #(
  parameter int unsigned MV_W   = 13,
  parameter int unsigned COST_W = 21
);
  logic                  dp_load_ram;
  logic                  dp_start;
  logic [6*MV_W-1:0]     dp_mv;
  logic [6*MV_W-1:0]     dp_pre_mv;
  logic                  dp_done;
  logic [1:0]            dp_best_mode;
  logic [COST_W-1:0]     dp_rd_cost_min;

  modport master (
    output dp_load_ram, dp_start, dp_mv, dp_pre_mv,
    input  dp_done, dp_best_mode, dp_rd_cost_min
  );

  modport slave (
    input  dp_load_ram, dp_start, dp_mv, dp_pre_mv,
    output dp_done, dp_best_mode, dp_rd_cost_min
  );
endinterface

// File: rtl/affine_cand_sched.sv
// Sequences up to MAX_CAND affine CPMV candidates through affine_top and keeps the cheapest.
// Optional per-candidate watchdog: define AFFINE_CAND_TIMEOUT_EN.
module affine_cand_sched #(
  parameter  int unsigned MAX_CAND    = 4,
  parameter  int unsigned MV_W        = 13,
  parameter  int unsigned COST_W      = 21,
  parameter  int unsigned TIMEOUT_CYC = 8192,
  localparam int unsigned IW          = $clog2(MAX_CAND),
  localparam int unsigned MVB         = 6 * MV_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cand_wr_en,
  input  logic [IW-1:0]     cand_wr_idx,
  input  logic [MVB-1:0]    cand_wr_mv,
  input  logic [IW:0]       num_cand,
  input  logic              run,
  output logic              busy,
  output logic              sched_done,
  output logic [IW-1:0]     best_idx,
  output logic [COST_W-1:0] best_cost,
  output logic [1:0]        best_mode,
  output logic [MVB-1:0]    best_mv,
  output logic              timeout_err,
  affine_cand_sched_if.master dp
);

  if (MAX_CAND < 2 || MAX_CAND > 16 || TIMEOUT_CYC < 2) begin : g_bad_param
    $error("affine_cand_sched: illegal MAX_CAND or TIMEOUT_CYC");
  end

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_RUN, S_CMP, S_FIN} state_e;

  state_e            state_q, state_d;
  logic [MVB-1:0]    slot_q [MAX_CAND];
  logic [MVB-1:0]    slot_d [MAX_CAND];
  logic [IW-1:0]     k_q, k_d;
  logic [IW:0]       n_q, n_d;
  logic [COST_W-1:0] cost_cap_q, cost_cap_d;
  logic [1:0]        mode_cap_q, mode_cap_d;
  logic [IW-1:0]     best_idx_q, best_idx_d;
  logic [COST_W-1:0] best_cost_q, best_cost_d;
  logic [1:0]        best_mode_q, best_mode_d;
  logic [MVB-1:0]    best_mv_q, best_mv_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              load_q, load_d;
  logic              start_q, start_d;
  logic [MVB-1:0]    mv_q, mv_d;
  logic [MVB-1:0]    pre_q, pre_d;

  logic              run_acc_c;
  logic              wd_expire_c;
  logic [IW:0]       n_clamp_c;
  logic              last_c;

  assign run_acc_c = (state_q == S_IDLE) && run;
  assign n_clamp_c = (num_cand > (IW+1)'(MAX_CAND)) ? (IW+1)'(MAX_CAND) : num_cand;
  assign last_c    = ({1'b0, k_q} == (n_q - (IW+1)'(1)));

`ifdef AFFINE_CAND_TIMEOUT_EN
  localparam int unsigned WD_W = $clog2(TIMEOUT_CYC);

  logic [WD_W-1:0] wd_q, wd_d;
  logic            timeout_q, timeout_d;

  // Counts RUN cycles of the current candidate; expires on the TIMEOUT_CYC-th without done.
  assign wd_expire_c = (state_q == S_RUN) && !dp.dp_done && (wd_q == WD_W'(TIMEOUT_CYC - 1));

  always_comb begin
    wd_d      = '0;
    timeout_d = timeout_q;
    if (run_acc_c) timeout_d = 1'b0;
    if ((state_q == S_RUN) && !dp.dp_done) wd_d = wd_q + WD_W'(1);
    if (wd_expire_c) timeout_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd_q      <= '0;
      timeout_q <= 1'b0;
    end else begin
      wd_q      <= wd_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout_err = timeout_q;
`else
  assign wd_expire_c = 1'b0;
  assign timeout_err = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    n_d         = n_q;
    slot_d      = slot_q;
    cost_cap_d  = cost_cap_q;
    mode_cap_d  = mode_cap_q;
    best_idx_d  = best_idx_q;
    best_cost_d = best_cost_q;
    best_mode_d = best_mode_q;
    best_mv_d   = best_mv_q;

    case (state_q)
      S_IDLE: begin
        if (cand_wr_en) slot_d[cand_wr_idx] = cand_wr_mv;
        if (run) begin
          n_d         = n_clamp_c;
          k_d         = '0;
          best_idx_d  = '0;
          best_cost_d = '1;
          best_mode_d = '0;
          best_mv_d   = '0;
          state_d     = (n_clamp_c == '0) ? S_FIN : S_LOAD;
        end
      end
      S_LOAD: state_d = S_RUN;
      S_RUN: begin
        if (dp.dp_done) begin
          cost_cap_d = dp.dp_rd_cost_min;
          mode_cap_d = dp.dp_best_mode;
          state_d    = S_CMP;
        end else if (wd_expire_c) begin
          // A hung candidate scores as all-ones so it can never win.
          cost_cap_d = '1;
          mode_cap_d = '0;
          state_d    = S_CMP;
        end
      end
      S_CMP: begin
        if (cost_cap_q < best_cost_q) begin
          best_idx_d  = k_q;
          best_cost_d = cost_cap_q;
          best_mode_d = mode_cap_q;
          best_mv_d   = slot_q[k_q];
        end
        if (last_c) begin
          state_d = S_FIN;
        end else begin
          k_d     = k_q + IW'(1);
          state_d = S_RUN;
        end
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Registered outputs follow the state being entered.
    busy_d  = (state_d != S_IDLE);
    done_d  = (state_d == S_FIN);
    load_d  = (state_d == S_LOAD);
    start_d = (state_d == S_RUN);
    mv_d    = '0;
    pre_d   = '0;
    if (state_d == S_RUN) begin
      mv_d = slot_q[k_d];
      if (k_d != '0) pre_d = slot_q[k_d - IW'(1)];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      for (int i = 0; i < MAX_CAND; i++) slot_q[i] <= '0;
      k_q         <= '0;
      n_q         <= '0;
      cost_cap_q  <= '0;
      mode_cap_q  <= '0;
      best_idx_q  <= '0;
      best_cost_q <= '1;
      best_mode_q <= '0;
      best_mv_q   <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      load_q      <= 1'b0;
      start_q     <= 1'b0;
      mv_q        <= '0;
      pre_q       <= '0;
    end else begin
      state_q     <= state_d;
      slot_q      <= slot_d;
      k_q         <= k_d;
      n_q         <= n_d;
      cost_cap_q  <= cost_cap_d;
      mode_cap_q  <= mode_cap_d;
      best_idx_q  <= best_idx_d;
      best_cost_q <= best_cost_d;
      best_mode_q <= best_mode_d;
      best_mv_q   <= best_mv_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      load_q      <= load_d;
      start_q     <= start_d;
      mv_q        <= mv_d;
      pre_q       <= pre_d;
    end
  end

  assign busy           = busy_q;
  assign sched_done     = done_q;
  assign best_idx       = best_idx_q;
  assign best_cost      = best_cost_q;
  assign best_mode      = best_mode_q;
  assign best_mv        = best_mv_q;
  assign dp.dp_load_ram = load_q;
  assign dp.dp_start    = start_q;
  assign dp.dp_mv       = mv_q;
  assign dp.dp_pre_mv   = pre_q;

endmodule

// File: tb/tb_affine_cand_sched.sv
// Randomised bench for affine_cand_sched: a timeline model predicts every output each cycle.
module tb_affine_cand_sched;
  localparam int unsigned MAX_CAND = 4;
  localparam int unsigned MV_W     = 13;
  localparam int unsigned COST_W   = 21;
  localparam int unsigned TO_CYC   = 16;
  localparam int unsigned IW       = 2;
  localparam int unsigned MVB      = 6 * MV_W;
  localparam logic [COST_W-1:0] CMAX = '1;

  logic              clk;
  logic              rst;
  logic              cand_wr_en;
  logic [IW-1:0]     cand_wr_idx;
  logic [MVB-1:0]    cand_wr_mv;
  logic [IW:0]       num_cand;
  logic              run;
  logic              busy;
  logic              sched_done;
  logic [IW-1:0]     best_idx;
  logic [COST_W-1:0] best_cost;
  logic [1:0]        best_mode;
  logic [MVB-1:0]    best_mv;
  logic              timeout_err;

  affine_cand_sched_if #(.MV_W(MV_W), .COST_W(COST_W)) dp ();

  affine_cand_sched #(
    .MAX_CAND(MAX_CAND), .MV_W(MV_W), .COST_W(COST_W), .TIMEOUT_CYC(TO_CYC)
  ) dut (
    .clk(clk), .rst(rst), .cand_wr_en(cand_wr_en), .cand_wr_idx(cand_wr_idx),
    .cand_wr_mv(cand_wr_mv), .num_cand(num_cand), .run(run), .busy(busy),
    .sched_done(sched_done), .best_idx(best_idx), .best_cost(best_cost),
    .best_mode(best_mode), .best_mv(best_mv), .timeout_err(timeout_err), .dp(dp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_fail = 0;

  // Model: slot contents, the active schedule (what the bench expects to happen), held results.
  logic [MVB-1:0]    m_slot [MAX_CAND];
  int                nx_d [MAX_CAND];
  logic [COST_W-1:0] nx_cost [MAX_CAND];
  logic [1:0]        nx_mode [MAX_CAND];
  int                s_d [MAX_CAND];
  logic [COST_W-1:0] s_cost [MAX_CAND];
  logic [1:0]        s_mode [MAX_CAND];
  logic [MVB-1:0]    s_mv [MAX_CAND];
  int                s_act = 0;
  int                s_l = 0;
  int                s_n = 0;
  int                h_idx = 0;
  logic [COST_W-1:0] h_cost = '1;
  int                h_mode = 0;
  logic [MVB-1:0]    h_mv = '0;
  int                h_to = 0;

  int                e_busy, e_done, e_load, e_start, e_idx, e_mode, e_to;
  logic [COST_W-1:0] e_cost;
  logic [MVB-1:0]    e_dmv, e_dpre, e_bmv;

  int                dpcnt = 0;
  int                dpk = 0;
  bit                spur = 1'b0;
  int                n_rise = 0;
  int                n_stc = 0;
  int                n_ld = 0;
  logic [MVB-1:0]    pre_k2;
  bit                prev_start = 1'b0;

  // Expected outputs at cycle c: candidate k occupies D_k start cycles plus one compare cycle.
  function automatic void model_at(input int c);
    int s;
    int dk;
    int fin;
    logic [COST_W-1:0] ck;
    e_busy = 0; e_done = 0; e_load = 0; e_start = 0;
    e_dmv = '0; e_dpre = '0;
    e_idx = h_idx; e_cost = h_cost; e_mode = h_mode; e_bmv = h_mv; e_to = h_to;
    if (s_act != 0 && c >= s_l) begin
      e_idx = 0; e_cost = CMAX; e_mode = 0; e_bmv = '0; e_to = 0;
      s = s_l + 1;
      for (int k = 0; k < s_n; k++) begin
        dk = (s_d[k] == 0) ? TO_CYC : s_d[k];
        if (c >= s && c < s + dk) begin
          e_start = 1;
          e_dmv   = s_mv[k];
          e_dpre  = (k == 0) ? '0 : s_mv[k-1];
        end
        if (s_d[k] == 0 && c >= s + dk) e_to = 1;
        if (c > s + dk) begin
          ck = (s_d[k] == 0) ? CMAX : s_cost[k];
          if (ck < e_cost) begin
            e_idx = k; e_cost = ck; e_mode = (s_d[k] == 0) ? 0 : int'(s_mode[k]); e_bmv = s_mv[k];
          end
        end
        s = s + dk + 1;
      end
      fin    = (s_n == 0) ? s_l : s;
      e_load = (s_n > 0 && c == s_l) ? 1 : 0;
      e_busy = (c <= fin) ? 1 : 0;
      e_done = (c == fin) ? 1 : 0;
    end
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, act, exp, cyc);
    end
  endtask

  // Behavioural affine_top: done in the D-th start cycle of each candidate, noise otherwise.
  always @(negedge clk) begin
    if (rst) begin
      dpcnt = 0;
      dpk = 0;
      dp.dp_done = 1'b0;
    end else begin
      dp.dp_done        = spur;
      dp.dp_rd_cost_min = COST_W'($urandom);
      dp.dp_best_mode   = 2'($urandom);
      if (dp.dp_start) begin
        dpcnt++;
        if (s_d[dpk] != 0 && dpcnt == s_d[dpk]) begin
          dp.dp_done        = 1'b1;
          dp.dp_rd_cost_min = s_cost[dpk];
          dp.dp_best_mode   = s_mode[dpk];
        end
      end else begin
        if (dpcnt != 0) dpk = (dpk + 1) % MAX_CAND;
        dpcnt = 0;
      end
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (rst) begin
      chk("rst_busy", busy, 0);
      chk("rst_sched_done", sched_done, 0);
      chk("rst_best_idx", best_idx, 0);
      chk("rst_best_cost", best_cost, CMAX);
      chk("rst_best_mode", best_mode, 0);
      chk("rst_best_mv", best_mv, 0);
      chk("rst_timeout_err", timeout_err, 0);
      chk("rst_load_ram", dp.dp_load_ram, 0);
      chk("rst_start", dp.dp_start, 0);
      chk("rst_dp_mv", dp.dp_mv, 0);
      chk("rst_dp_pre_mv", dp.dp_pre_mv, 0);
    end else begin
      model_at(cyc);
      chk("busy", busy, e_busy);
      chk("sched_done", sched_done, e_done);
      chk("best_idx", best_idx, e_idx);
      chk("best_cost", best_cost, e_cost);
      chk("best_mode", best_mode, e_mode);
      chk("best_mv", best_mv, e_bmv);
      chk("timeout_err", timeout_err, e_to);
      chk("dp_load_ram", dp.dp_load_ram, e_load);
      chk("dp_start", dp.dp_start, e_start);
      chk("dp_mv", dp.dp_mv, e_dmv);
      chk("dp_pre_mv", dp.dp_pre_mv, e_dpre);
      if (dp.dp_start && !prev_start) begin
        n_rise++;
        if (n_rise == 3) pre_k2 = dp.dp_pre_mv;
      end
      if (dp.dp_start) n_stc++;
      if (dp.dp_load_ram) n_ld++;
    end
    prev_start = dp.dp_start;
  end

  function automatic logic [MVB-1:0] pack6(input int a, input int b, input int c,
                                           input int d, input int e, input int f);
    return {MV_W'(a), MV_W'(b), MV_W'(c), MV_W'(d), MV_W'(e), MV_W'(f)};
  endfunction

  function automatic logic [MVB-1:0] rnd_mv();
    logic [95:0] r;
    r = {$urandom, $urandom, $urandom};
    return MVB'(r);
  endfunction

  task automatic clr_cnt();
    n_rise = 0; n_stc = 0; n_ld = 0;
  endtask

  task automatic wr(input int idx, input logic [MVB-1:0] mv);
    @(posedge clk); #1;
    cand_wr_en = 1'b1; cand_wr_idx = IW'(idx); cand_wr_mv = mv;
    m_slot[idx] = mv;
    @(posedge clk); #1;
    cand_wr_en = 1'b0;
  endtask

  task automatic start_run(input int ncand, output int c_run);
    @(posedge clk); #1;
    if (s_act != 0) begin
      model_at(32'h3fff_ffff);
      h_idx = e_idx; h_cost = e_cost; h_mode = e_mode; h_mv = e_bmv; h_to = e_to;
    end
    for (int k = 0; k < MAX_CAND; k++) begin
      s_d[k] = nx_d[k]; s_cost[k] = nx_cost[k]; s_mode[k] = nx_mode[k]; s_mv[k] = m_slot[k];
    end
    s_n = (ncand > MAX_CAND) ? MAX_CAND : ncand;
    s_l = cyc + 1;
    s_act = 1;
    dpk = 0;
    c_run = cyc;
    num_cand = (IW+1)'(ncand);
    run = 1'b1;
    @(posedge clk); #1;
    run = 1'b0;
  endtask

  task automatic wait_done(output int dc);
    bit seen;
    seen = 1'b0;
    dc = -1;
    for (int i = 0; i < 2000 && !seen; i++) begin
      @(negedge clk);
      if (sched_done) begin seen = 1'b1; dc = cyc; end
    end
    if (!seen) chk("wait_sched_done_expired", 0, 1);
  endtask

  task automatic wait_rise(input int target);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 500 && !seen; i++) begin
      @(negedge clk);
      if (n_rise >= target) seen = 1'b1;
    end
    if (!seen) chk("wait_start_expired", 0, 1);
  endtask

  task automatic model_reset();
    s_act = 0; h_idx = 0; h_cost = CMAX; h_mode = 0; h_mv = '0; h_to = 0;
    for (int k = 0; k < MAX_CAND; k++) m_slot[k] = '0;
  endtask

  initial begin
    int c0;
    int dc;
    int nw;
    logic [MVB-1:0] sl1;
    logic [MVB-1:0] junk;

    rst = 1'b1; cand_wr_en = 1'b0; cand_wr_idx = '0; cand_wr_mv = '0;
    num_cand = '0; run = 1'b0;
    dp.dp_done = 1'b0; dp.dp_best_mode = '0; dp.dp_rd_cost_min = '0;
    for (int k = 0; k < MAX_CAND; k++) begin
      m_slot[k] = '0; nx_d[k] = 1; nx_cost[k] = '0; nx_mode[k] = '0;
      s_d[k] = 1; s_cost[k] = '0; s_mode[k] = '0; s_mv[k] = '0;
    end
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Single candidate: done after 10 start cycles, cost 500, mode 2.
    wr(0, pack6(-92, -20, -92, -20, -92, -20));
    nx_d[0] = 10; nx_cost[0] = 500; nx_mode[0] = 2;
    clr_cnt();
    start_run(1, c0);
    wait_done(dc);
    chk("t1_done_cycle", dc, c0 + 13);
    chk("t1_load_cycles", n_ld, 1);
    chk("t1_start_cycles", n_stc, 10);
    chk("t1_best_idx", best_idx, 0);
    chk("t1_best_cost", best_cost, 500);
    chk("t1_best_mode", best_mode, 2);

    // Minimum selection with a tie: 900, 300, 300, 700.
    for (int k = 0; k < 4; k++) wr(k, rnd_mv());
    sl1 = m_slot[1];
    nx_d[0] = 3; nx_d[1] = 5; nx_d[2] = 2; nx_d[3] = 4;
    nx_cost[0] = 900; nx_cost[1] = 300; nx_cost[2] = 300; nx_cost[3] = 700;
    nx_mode[0] = 1; nx_mode[1] = 2; nx_mode[2] = 3; nx_mode[3] = 0;
    clr_cnt();
    start_run(4, c0);
    wait_done(dc);
    chk("t2_best_idx", best_idx, 1);
    chk("t2_best_cost", best_cost, 300);
    chk("t2_best_mode", best_mode, 2);
    chk("t2_pre_mv_cand2", pre_k2, sl1);

    // Zero candidates.
    clr_cnt();
    start_run(0, c0);
    wait_done(dc);
    chk("t3_done_cycle", dc, c0 + 1);
    chk("t3_start_count", n_rise, 0);
    chk("t3_best_cost", best_cost, CMAX);

    // Count beyond MAX_CAND clamps to 4.
    for (int k = 0; k < 4; k++) begin nx_d[k] = 2; nx_cost[k] = COST_W'(50 - k); end
    clr_cnt();
    start_run(7, c0);
    wait_done(dc);
    chk("t3_clamp_start_count", n_rise, 4);
    chk("t3_clamp_best_idx", best_idx, 3);

    // run and slot writes during RUN are dropped.
    for (int k = 0; k < 4; k++) nx_d[k] = 6;
    clr_cnt();
    start_run(4, c0);
    for (int i = 0; i < 50 && n_stc < 2; i++) @(negedge clk);
    junk = ~m_slot[0];
    @(posedge clk); #1;
    run = 1'b1; num_cand = 3'd1; cand_wr_en = 1'b1; cand_wr_idx = '0; cand_wr_mv = junk;
    @(posedge clk); #1;
    run = 1'b0; cand_wr_en = 1'b0;
    wait_done(dc);
    nx_d[0] = 2;
    start_run(1, c0);
    wait_done(dc);

    // Spurious done while idle.
    @(posedge clk); #1 spur = 1'b1;
    repeat (3) @(posedge clk);
    #1 spur = 1'b0;
    repeat (2) @(posedge clk);

    // Reset during RUN of candidate 2.
    for (int k = 0; k < 4; k++) nx_d[k] = 4;
    clr_cnt();
    start_run(4, c0);
    wait_rise(3);
    @(posedge clk); #1;
    rst = 1'b1;
    model_reset();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    nx_d[0] = 3; nx_d[1] = 3; nx_cost[0] = 10; nx_cost[1] = 20;
    start_run(2, c0);
    wait_done(dc);
    chk("t5_best_idx", best_idx, 0);
    chk("t5_best_mv_cleared", best_mv, 0);

    // Randomised sequences.
    for (int it = 0; it < 25; it++) begin
      nw = $urandom_range(0, 3);
      for (int w = 0; w < nw; w++) wr($urandom_range(0, 3), rnd_mv());
      for (int k = 0; k < MAX_CAND; k++) begin
        nx_d[k]    = $urandom_range(1, 8);
        nx_cost[k] = ($urandom_range(0, 7) == 0) ? CMAX : COST_W'($urandom_range(0, 40));
        nx_mode[k] = 2'($urandom);
      end
      start_run($urandom_range(0, 7), c0);
      wait_done(dc);
      repeat ($urandom_range(0, 3)) @(posedge clk);
    end

`ifdef AFFINE_CAND_TIMEOUT_EN
    // Candidate 0 hangs, candidate 1 costs 40.
    wr(0, rnd_mv());
    wr(1, rnd_mv());
    nx_d[0] = 0; nx_d[1] = 5; nx_cost[0] = 7; nx_cost[1] = 40; nx_mode[1] = 1;
    start_run(2, c0);
    wait_done(dc);
    chk("wd_timeout_err", timeout_err, 1);
    chk("wd_best_idx", best_idx, 1);
    chk("wd_best_cost", best_cost, 40);
`endif

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
